// File: rtl/alarm_pkg.sv
// Shared widths, time-of-day limits and the range check used by the
// alarm timebase and its countdown sub-blocks.
package alarm_pkg;

  localparam int HOUR_W = 5;
  localparam int MIN_W  = 6;
  localparam int SEC_W  = 6;

  localparam logic [SEC_W-1:0]  SEC_MAX  = 6'd59;
  localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;
  localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;

  typedef struct packed {
    logic [HOUR_W-1:0] hour;
    logic [MIN_W-1:0]  min;
    logic [SEC_W-1:0]  sec;
  } tod_t;

  // True when an hour/minute pair is a legal 24-hour clock setting.
  function automatic logic hm_valid(input logic [HOUR_W-1:0] h,
                                    input logic [MIN_W-1:0]  m);
    return (h <= HOUR_MAX) && (m <= MIN_MAX);
  endfunction

endpackage

// File: rtl/sec_countdown.sv
// Seconds countdown: reloads to LOAD while disabled, decrements on each
// tick while enabled and saturates at zero.
module sec_countdown #(
  parameter int LOAD = 60
) (
  input  logic Clk,
  input  logic Reset,
  input  logic En,
  input  logic Tick,
  output logic Zero
);

  localparam int CW = $clog2(LOAD + 1);
  localparam logic [CW-1:0] LOAD_V = CW'(LOAD);

  logic [CW-1:0] count;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      count <= LOAD_V;
    end else if (!En) begin
      count <= LOAD_V;
    end else if (Tick && (count != '0)) begin
      count <= count - CW'(1);
    end
  end

  assign Zero = (count == '0);

endmodule

// File: rtl/alarm_timebase.sv
// 1 Hz timebase with 24-hour time of day, alarm comparator and the
// ring-timeout / snooze countdowns used by the alarm control unit.
module alarm_timebase
  import alarm_pkg::*;
#(
  parameter int TICK_DIV    = 50_000_000,
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_SECS = 300
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Set_Time,
  input  logic              Set_Alarm,
  input  logic [HOUR_W-1:0] Hour_In,
  input  logic [MIN_W-1:0]  Min_In,
  input  logic              EN_STOP,
  input  logic              EN_SNZ,
  output logic              AA,
  output logic              C0,
  output logic              CS0,
  output logic              Tick,
  output logic [HOUR_W-1:0] Hour,
  output logic [MIN_W-1:0]  Min,
  output logic [SEC_W-1:0]  Sec
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0]     pre_cnt;
  logic              tick_i;
  logic              load_time;
  logic              load_alarm;
  tod_t              tod;
  tod_t              tod_next;
  logic [HOUR_W-1:0] alarm_hour;
  logic [MIN_W-1:0]  alarm_min;
  logic              aa_q;

  assign tick_i     = (pre_cnt == PRE_LAST);
  assign load_time  = Set_Time  && hm_valid(Hour_In, Min_In);
  assign load_alarm = Set_Alarm && hm_valid(Hour_In, Min_In);

  // An accepted time load realigns the second boundary to the load edge.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      pre_cnt <= '0;
    end else if (load_time || tick_i) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + PW'(1);
    end
  end

  always_comb begin
    tod_next = tod;
    if (tod.sec == SEC_MAX) begin
      tod_next.sec = '0;
      if (tod.min == MIN_MAX) begin
        tod_next.min  = '0;
        tod_next.hour = (tod.hour == HOUR_MAX) ? '0 : tod.hour + HOUR_W'(1);
      end else begin
        tod_next.min = tod.min + MIN_W'(1);
      end
    end else begin
      tod_next.sec = tod.sec + SEC_W'(1);
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      tod <= '0;
    end else if (load_time) begin
      tod <= '{hour: Hour_In, min: Min_In, sec: '0};
    end else if (tick_i) begin
      tod <= tod_next;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      alarm_hour <= '0;
      alarm_min  <= '0;
    end else if (load_alarm) begin
      alarm_hour <= Hour_In;
      alarm_min  <= Min_In;
    end
  end

  // Only a tick-driven arrival at hh:mm:00 counts; a direct load never rings.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      aa_q <= 1'b0;
    end else begin
      aa_q <= tick_i && !load_time && (tod_next.sec == '0) &&
              (tod_next.hour == alarm_hour) && (tod_next.min == alarm_min);
    end
  end

  sec_countdown #(.LOAD(RING_SECS)) u_ring (
    .Clk   (Clk),
    .Reset (Reset),
    .En    (EN_STOP),
    .Tick  (tick_i),
    .Zero  (C0)
  );

  sec_countdown #(.LOAD(SNOOZE_SECS)) u_snooze (
    .Clk   (Clk),
    .Reset (Reset),
    .En    (EN_SNZ),
    .Tick  (tick_i),
    .Zero  (CS0)
  );

  assign AA   = aa_q;
  assign Tick = tick_i;
  assign Hour = tod.hour;
  assign Min  = tod.min;
  assign Sec  = tod.sec;

endmodule

// File: tb/tb_alarm_timebase.sv
// Bench for alarm_timebase: directed scenarios plus random traffic, all
// outputs compared every cycle against a seconds-of-day reference model.
module tb_alarm_timebase;

  localparam int TICK_DIV = 4;
  localparam int RING     = 3;
  localparam int SNZ      = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       set_time = 1'b0;
  logic       set_alarm = 1'b0;
  logic [4:0] hour_in = '0;
  logic [5:0] min_in = '0;
  logic       en_stop = 1'b0;
  logic       en_snz = 1'b0;
  logic       aa, c0, cs0, tick;
  logic [4:0] hour;
  logic [5:0] min;
  logic [5:0] sec;

  alarm_timebase #(
    .TICK_DIV    (TICK_DIV),
    .RING_SECS   (RING),
    .SNOOZE_SECS (SNZ)
  ) dut (
    .Clk       (clk),
    .Reset     (rst_n),
    .Set_Time  (set_time),
    .Set_Alarm (set_alarm),
    .Hour_In   (hour_in),
    .Min_In    (min_in),
    .EN_STOP   (en_stop),
    .EN_SNZ    (en_snz),
    .AA        (aa),
    .C0        (c0),
    .CS0       (cs0),
    .Tick      (tick),
    .Hour      (hour),
    .Min       (min),
    .Sec       (sec)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // scoreboard state
  int n_cmp = 0;
  int n_bad = 0;
  int aa_cnt = 0;
  logic [10:0] exp_q[$];

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // reference model: time as seconds of day, alarm as minutes of day
  int m_phase, m_tod, m_alarm, m_ring, m_snz;
  bit m_aa;

  function automatic void model_reset();
    m_phase = 0;
    m_tod   = 0;
    m_alarm = 0;
    m_ring  = RING;
    m_snz   = SNZ;
    m_aa    = 1'b0;
    exp_q.delete();
  endfunction

  always @(posedge clk) begin
    if (rst_n) begin
      bit tk, st_ok, sa_ok;
      int old_alarm;
      tk        = (m_phase == TICK_DIV - 1);
      st_ok     = set_time  && (hour_in <= 23) && (min_in <= 59);
      sa_ok     = set_alarm && (hour_in <= 23) && (min_in <= 59);
      old_alarm = m_alarm;
      if (st_ok) begin
        m_tod   = hour_in * 3600 + min_in * 60;
        m_phase = 0;
      end else begin
        m_phase = (m_phase + 1) % TICK_DIV;
        if (tk) m_tod = (m_tod + 1) % 86400;
      end
      m_aa = tk && !st_ok && (m_tod == old_alarm * 60);
      if (m_aa) exp_q.push_back({5'(m_tod / 3600), 6'((m_tod / 60) % 60)});
      if (sa_ok) m_alarm = hour_in * 60 + min_in;
      if (!en_stop) m_ring = RING;
      else if (tk && m_ring > 0) m_ring--;
      if (!en_snz) m_snz = SNZ;
      else if (tk && m_snz > 0) m_snz--;
    end
  end

  // per-cycle checker, sampled just after the falling edge
  always @(negedge clk) begin
    #1;
    chk("tick", tick, (m_phase == TICK_DIV - 1) ? 1 : 0);
    chk("hour", hour, m_tod / 3600);
    chk("min",  min,  (m_tod / 60) % 60);
    chk("sec",  sec,  m_tod % 60);
    chk("aa",   aa,   m_aa);
    chk("c0",   c0,   (m_ring == 0) ? 1 : 0);
    chk("cs0",  cs0,  (m_snz == 0) ? 1 : 0);
    if (aa) begin
      aa_cnt++;
      if (exp_q.size() == 0) chk("aa_unexpected", 1, 0);
      else chk("aa_time", {hour, min}, exp_q.pop_front());
    end
  end

  // driver tasks
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_set_time(input int h, input int m);
    set_time = 1'b1;
    hour_in  = 5'(h);
    min_in   = 6'(m);
    @(negedge clk);
    set_time = 1'b0;
  endtask

  task automatic do_set_alarm(input int h, input int m);
    set_alarm = 1'b1;
    hour_in   = 5'(h);
    min_in    = 6'(m);
    @(negedge clk);
    set_alarm = 1'b0;
  endtask

  task automatic wait_phase(input int target);
    int n = 0;
    while (m_phase != target && n < 2 * TICK_DIV) begin
      @(negedge clk);
      n++;
    end
    chk("wait_phase", m_phase, target);
  endtask

  task automatic apply_reset(input int hold);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_cs0", cs0, 0);
    chk("rst_sec", sec, 0);
    cyc(hold);
    rst_n = 1'b1;
  endtask

  initial begin
    int base;
    model_reset();

    // 1: reset hold and first tick
    cyc(3);
    chk("t1_tick_in_reset", tick, 0);
    rst_n = 1'b1;
    cyc(3);
    chk("t1_first_tick", tick, 1);
    cyc(1);
    chk("t1_sec_after_tick", sec, 1);
    chk("t1_tick_low", tick, 0);

    // 2: rollover and out-of-range load
    do_set_time(23, 59);
    cyc(60 * TICK_DIV);
    chk("t2_hour", hour, 0);
    chk("t2_min",  min,  0);
    chk("t2_sec",  sec,  0);
    do_set_time(24, 10);
    chk("t2_bad_hour", hour, 0);
    chk("t2_bad_min",  min,  0);

    // 3: alarm pulse at 07:30:00 only
    do_set_alarm(7, 30);
    do_set_time(7, 29);
    base = aa_cnt;
    cyc(62 * TICK_DIV);
    chk("t3_aa_once", aa_cnt - base, 1);
    do_set_time(7, 30);
    cyc(2 * TICK_DIV);
    chk("t3_no_aa_on_load", aa_cnt - base, 1);

    // 4: ring countdown
    wait_phase(0);
    en_stop = 1'b1;
    cyc(3 * TICK_DIV - 1);
    chk("t4_c0_early", c0, 0);
    cyc(1);
    chk("t4_c0_set", c0, 1);
    cyc(2 * TICK_DIV);
    chk("t4_c0_hold", c0, 1);
    en_stop = 1'b0;
    cyc(1);
    chk("t4_c0_drop", c0, 0);
    wait_phase(0);
    en_stop = 1'b1;
    cyc(3 * TICK_DIV - 1);
    chk("t4_c0_rearm_early", c0, 0);
    cyc(1);
    chk("t4_c0_rearm", c0, 1);
    en_stop = 1'b0;

    // 5: snooze partial run, full run, reset mid-count
    wait_phase(0);
    en_snz = 1'b1;
    cyc(2 * TICK_DIV);
    en_snz = 1'b0;
    cyc(1);
    wait_phase(0);
    en_snz = 1'b1;
    cyc(SNZ * TICK_DIV - 1);
    chk("t5_cs0_early", cs0, 0);
    cyc(1);
    chk("t5_cs0_set", cs0, 1);
    en_snz = 1'b0;
    cyc(1);
    wait_phase(0);
    en_snz = 1'b1;
    cyc(4 * TICK_DIV);
    apply_reset(2);
    cyc(SNZ * TICK_DIV - 1);
    chk("t5_cs0_after_rst_early", cs0, 0);
    cyc(1);
    chk("t5_cs0_after_rst", cs0, 1);
    en_snz = 1'b0;

    // 6: load coincident with tick
    wait_phase(TICK_DIV - 1);
    do_set_time(12, 34);
    chk("t6_hour", hour, 12);
    chk("t6_min",  min,  34);
    chk("t6_sec",  sec,  0);
    cyc(TICK_DIV - 2);
    chk("t6_no_tick_yet", tick, 0);
    cyc(1);
    chk("t6_tick", tick, 1);

    // random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      int r;
      @(negedge clk);
      set_time  = 1'b0;
      set_alarm = 1'b0;
      rst_n     = 1'b1;
      r = $urandom_range(0, 399);
      if (r < 8) begin
        set_time = 1'b1;
        hour_in  = 5'($urandom_range(0, 25));
        min_in   = 6'($urandom_range(0, 61));
      end else if (r < 14) begin
        int am;
        am = (r < 11) ? (m_tod / 60 + 1) % 1440 : $urandom_range(0, 1439);
        set_alarm = 1'b1;
        hour_in   = 5'(am / 60);
        min_in    = 6'(am % 60);
      end else if (r == 14) begin
        set_time  = 1'b1;
        set_alarm = 1'b1;
        hour_in   = 5'($urandom_range(0, 23));
        min_in    = 6'($urandom_range(58, 59));
      end else if (r == 15) begin
        rst_n = 1'b0;
        model_reset();
      end
      if ($urandom_range(0, 39) == 0) en_stop = ~en_stop;
      if ($urandom_range(0, 59) == 0) en_snz  = ~en_snz;
    end
    @(negedge clk);
    set_time  = 1'b0;
    set_alarm = 1'b0;
    rst_n     = 1'b1;
    cyc(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
